lc3_controller_param: RTL

//   Parametrised LC3 multi-cycle control FSM, the successor to the fixed 10-state controller.

---
 rtl/lc3_controller_param.sv | 134 +++++++++++++
 1 files changed

// File: rtl/lc3_controller_param.sv
// lc3_controller_param: multi-cycle LC3 control FSM with memory-wait timeout,
// sticky error, instruction-boundary stall and retired-instruction counter.
`default_nettype none

module lc3_controller_param #(
  parameter int STATE_W     = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8,
  parameter int CNT_W       = 16,
  parameter int HALT_ON_ERR = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         c_control,
  input  logic               complete,
  input  logic               stall,
  output logic [STATE_W-1:0] state,
  output logic               mem_req,
  output logic               mem_we,
  output logic               error,
  output logic [CNT_W-1:0]   instr_count
);

  typedef enum logic [3:0] {
    S_FETCH            = 4'd0,
    S_DECODE           = 4'd1,
    S_EXEC_ALU         = 4'd2,
    S_COMPUTE_TPC      = 4'd3,
    S_COMPUTE_MEM_ADDR = 4'd4,
    S_INDIRECT_READ    = 4'd5,
    S_READ_MEM         = 4'd6,
    S_WRITE_MEM        = 4'd7,
    S_UPDATE_REG       = 4'd8,
    S_UPDATE_PC        = 4'd9,
    S_MEM_ERROR        = 4'd14,
    S_INVALID          = 4'd15
  } state_t;

  localparam bit               TMO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_EN ? TMO_W'(MEM_TIMEOUT - 1) : '0;
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               error_q, error_d;

  logic [1:0]         ctl_type;
  logic               ctl_store_pc;
  logic [1:0]         ctl_mode;
  logic               ctl_load;
  logic               in_mem;
  logic               retire;

  assign ctl_type     = c_control[5:4];
  assign ctl_store_pc = c_control[3];
  assign ctl_mode     = c_control[2:1];
  assign ctl_load     = c_control[0];

  assign in_mem = (state_q == S_FETCH) || (state_q == S_INDIRECT_READ) ||
                  (state_q == S_READ_MEM) || (state_q == S_WRITE_MEM);
  assign retire = (state_q == S_UPDATE_PC) && !stall;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:       if (complete) state_d = S_DECODE;
      S_DECODE: begin
        case (ctl_type)
          2'b00:   state_d = S_EXEC_ALU;
          2'b01:   state_d = S_COMPUTE_TPC;
          2'b10:   state_d = S_COMPUTE_MEM_ADDR;
          default: state_d = S_INVALID;
        endcase
      end
      S_EXEC_ALU:    state_d = S_UPDATE_REG;
      S_COMPUTE_TPC: state_d = ctl_store_pc ? S_UPDATE_REG : S_UPDATE_PC;
      S_COMPUTE_MEM_ADDR: begin
        case (ctl_mode)
          2'b00:   state_d = S_INDIRECT_READ;
          2'b01:   state_d = S_READ_MEM;
          2'b10:   state_d = S_WRITE_MEM;
          default: state_d = S_UPDATE_REG;
        endcase
      end
      S_INDIRECT_READ: if (complete) state_d = ctl_load ? S_READ_MEM : S_WRITE_MEM;
      S_READ_MEM:    if (complete) state_d = S_UPDATE_REG;
      S_WRITE_MEM:   if (complete) state_d = S_UPDATE_PC;
      S_UPDATE_REG:  state_d = S_UPDATE_PC;
      S_UPDATE_PC:   if (!stall) state_d = S_FETCH;
      S_MEM_ERROR,
      S_INVALID:     if (HALT_ON_ERR == 0) state_d = S_UPDATE_PC;
      default:       state_d = S_INVALID;
    endcase

    // A completing access in the last allowed cycle beats the timeout.
    if (TMO_EN && in_mem && !complete && (wait_q == TMO_LAST))
      state_d = S_MEM_ERROR;
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)
      wait_d = '0;
    else if (in_mem && !complete && (wait_q != TMO_MAX))
      wait_d = wait_q + TMO_W'(1);
  end

  assign error_d = error_q || (state_d == S_INVALID) || (state_d == S_MEM_ERROR);
  assign count_d = retire ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign state       = STATE_W'(state_q);
  assign mem_req     = in_mem;
  assign mem_we      = (state_q == S_WRITE_MEM);
  assign error       = error_q;
  assign instr_count = count_q;

endmodule

`default_nettype wire
